vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.
- Sits between the system clock and the Julia-set pixel pipeline and video DAC.
- Emits a pixel clock-enable (no derived clock), pixel coordinates, line/frame strobes, and hs/vs/blank.
- Sync/blank can be delayed to line up with a multi-stage colour pipeline.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel clock-enable and delayable sync/blank.
// Optional completed-frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   PIPE_DLY = 0,
    parameter int   CW       = 11
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          en,
    output logic          pixel_ce,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic [2:0] IDLE = {~HS_POL, ~VS_POL, 1'b0};

    logic [3:0]    div;
    logic          run;
    logic          wrapped;
    logic          x_end;
    logic          y_end;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic [2:0]    dec;
    logic [2:0]    d0;

    // run gates the first divider step so the first pixel_ce lands CLK_DIV edges after release
    assign pixel_ce = en & run & (div == 4'(CLK_DIV - 1));
    assign x_end    = DrawX == CW'(H_TOTAL - 1);
    assign y_end    = DrawY == CW'(V_TOTAL - 1);
    assign x_nxt    = !pixel_ce ? DrawX : x_end ? '0 : DrawX + 1'b1;
    assign y_nxt    = !(pixel_ce && x_end) ? DrawY : y_end ? '0 : DrawY + 1'b1;
    assign sync     = 1'b0;

    always_comb begin
        dec = {(int'(x_nxt) >= HS_BEG && int'(x_nxt) < HS_END) ? HS_POL : ~HS_POL,
               (int'(y_nxt) >= VS_BEG && int'(y_nxt) < VS_END) ? VS_POL : ~VS_POL,
               int'(x_nxt) < H_ACTIVE && int'(y_nxt) < V_ACTIVE};
    end

    assign line_start  = pixel_ce & wrapped & (DrawX == '0);
    assign frame_start = line_start & (DrawY == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div     <= '0;
            run     <= 1'b0;
            wrapped <= 1'b0;
            DrawX   <= '0;
            DrawY   <= '0;
            d0      <= IDLE;
        end else begin
            run   <= 1'b1;
            DrawX <= x_nxt;
            DrawY <= y_nxt;
            if (run && en)
                div <= (div == 4'(CLK_DIV - 1)) ? '0 : div + 1'b1;
            if (pixel_ce && x_end)
                wrapped <= 1'b1;
            // first load after release captures the decode of pixel (0,0)
            if (pixel_ce || !run)
                d0 <= dec;
        end
    end

    if (PIPE_DLY == 0) begin : g_nodly
        assign {hs, vs, blank} = d0;
    end else begin : g_dly
        logic [2:0] sr [PIPE_DLY];
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                for (int i = 0; i < PIPE_DLY; i++)
                    sr[i] <= IDLE;
            end else if (pixel_ce) begin
                sr[0] <= d0;
                for (int i = 1; i < PIPE_DLY; i++)
                    sr[i] <= sr[i-1];
            end
        end
        assign {hs, vs, blank} = sr[PIPE_DLY-1];
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            frame_cnt <= '0;
        else if (pixel_ce && x_end && y_end)
            frame_cnt <= frame_cnt + 1'b1;
    end
`else
    assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default, delayed-pipe and small-raster instances.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic a_rst, a_en, a_ce, a_ls, a_fs, a_hs, a_vs, a_bl, a_sy;
    logic [10:0] a_x, a_y;
    logic [15:0] a_fc;
    logic b_rst, b_en, b_ce, b_ls, b_fs, b_hs, b_vs, b_bl, b_sy;
    logic [10:0] b_x, b_y;
    logic [15:0] b_fc;
    logic c_rst, c_en, c_ce, c_ls, c_fs, c_hs, c_vs, c_bl, c_sy;
    logic [3:0] c_x, c_y;
    logic [15:0] c_fc;

    vga_timing_gen u_def (
        .Clk(clk), .Reset_n(a_rst), .en(a_en), .pixel_ce(a_ce), .DrawX(a_x), .DrawY(a_y),
        .line_start(a_ls), .frame_start(a_fs), .hs(a_hs), .vs(a_vs), .blank(a_bl),
        .sync(a_sy), .frame_cnt(a_fc)
    );

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(3)) u_dly (
        .Clk(clk), .Reset_n(b_rst), .en(b_en), .pixel_ce(b_ce), .DrawX(b_x), .DrawY(b_y),
        .line_start(b_ls), .frame_start(b_fs), .hs(b_hs), .vs(b_vs), .blank(b_bl),
        .sync(b_sy), .frame_cnt(b_fc)
    );

    // 15x8 raster, positive syncs, 3 clocks per pixel
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .CW(4)
    ) u_sml (
        .Clk(clk), .Reset_n(c_rst), .en(c_en), .pixel_ce(c_ce), .DrawX(c_x), .DrawY(c_y),
        .line_start(c_ls), .frame_start(c_fs), .hs(c_hs), .vs(c_vs), .blank(c_bl),
        .sync(c_sy), .frame_cnt(c_fc)
    );

    task automatic test_reset;
        logic [46:0] want;
        a_rst = 1'b0;
        a_en  = 1'b1;
        repeat (3) @(negedge clk);
        want = {1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        total++;
        if ({a_ce, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_bl, a_sy, a_fc} !== want) begin
            bad++;
            $display("FAIL reset_vals got=%h want=%h",
                     {a_ce, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_bl, a_sy, a_fc}, want);
        end
        a_rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            total++;
            if (a_ce !== (i % 2 == 0)) begin
                bad++;
                $display("FAIL ce_start edge=%0d got=%b want=%b", i, a_ce, (i % 2 == 0));
            end
            if (i == 1) begin
                total++;
                if ({a_bl, a_hs, a_x} !== {1'b1, 1'b1, 11'd0}) begin
                    bad++;
                    $display("FAIL first_pixel bl/hs/x got=%b/%b/%0d want=1/1/0", a_bl, a_hs, a_x);
                end
            end
        end
        total++;
        if (a_x !== 11'd2) begin
            bad++;
            $display("FAIL x_after_6 got=%0d want=2", a_x);
        end
    endtask

    task automatic test_line;
        logic [15:0] want;
        for (int ex = 2; ex < 800; ex++) begin
            want = {11'(ex), (ex >= 656 && ex < 752) ? 1'b0 : 1'b1, ex < 640, 1'b1, 1'b1, 1'b0};
            total++;
            if ({a_x, a_hs, a_bl, a_vs, a_ce, a_ls} !== want) begin
                bad++;
                $display("FAIL line0 x=%0d got=%h want=%h", ex, {a_x, a_hs, a_bl, a_vs, a_ce, a_ls}, want);
            end
            repeat (2) @(negedge clk);
        end
        total++;
        if ({a_x, a_y, a_ls, a_fs} !== {11'd0, 11'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL line_wrap x/y/ls/fs got=%0d/%0d/%b/%b want=0/1/1/0", a_x, a_y, a_ls, a_fs);
        end
    endtask

    task automatic test_en;
        repeat (2 * 299) @(negedge clk);
        @(negedge clk);
        total++;
        if ({a_x, a_ce} !== {11'd300, 1'b0}) begin
            bad++;
            $display("FAIL en_pre x/ce got=%0d/%b want=300/0", a_x, a_ce);
        end
        a_en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            total++;
            if ({a_x, a_hs, a_vs, a_bl, a_ce} !== {11'd300, 1'b1, 1'b1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL en_hold cyc=%0d x=%0d hs=%b vs=%b bl=%b ce=%b want 300/1/1/1/0",
                         i, a_x, a_hs, a_vs, a_bl, a_ce);
            end
        end
        a_en = 1'b1;
        @(negedge clk);
        total++;
        if ({a_x, a_ce} !== {11'd300, 1'b1}) begin
            bad++;
            $display("FAIL en_resume x/ce got=%0d/%b want=300/1", a_x, a_ce);
        end
        @(negedge clk);
        total++;
        if (a_x !== 11'd301) begin
            bad++;
            $display("FAIL en_advance x got=%0d want=301", a_x);
        end
    endtask

    task automatic test_pipe_dly;
        int px;
        int pm;
        logic [13:0] want;
        b_en  = 1'b1;
        @(negedge clk);
        b_rst = 1'b1;
        for (int i = 1; i <= 820; i++) begin
            @(negedge clk);
            px = i - 4;
            pm = px % 800;
            // hs/blank lag DrawX by three pixel steps; idle values before the pipe fills
            want = {11'((i - 1) % 800),
                    (px >= 0 && pm >= 656 && pm < 752) ? 1'b0 : 1'b1,
                    px >= 0 && pm < 640, 1'b1};
            total++;
            if ({b_x, b_hs, b_bl, b_vs} !== want) begin
                bad++;
                $display("FAIL pipe_dly step=%0d got=%h want=%h", i, {b_x, b_hs, b_bl, b_vs}, want);
            end
        end
    endtask

    task automatic test_frame;
        int p = 0;
        int fs1 = -1;
        int fs2 = -1;
        int x, y;
        bit st, ece;
        logic [28:0] want;
        c_en = 1'b1;
        @(negedge clk);
        c_rst = 1'b1;
        for (int c = 1; c <= 723; c++) begin
            @(negedge clk);
            ece = c >= 3 && c % 3 == 0;
            total++;
            if (c_ce !== ece) begin
                bad++;
                $display("FAIL sml_ce cyc=%0d got=%b want=%b", c, c_ce, ece);
            end
            if (c_fs === 1'b1) begin
                if (fs1 < 0) fs1 = c;
                else fs2 = c;
            end
            if (ece) begin
                x  = p % 15;
                y  = (p / 15) % 8;
                st = p >= 15;
                want = {4'(x), 4'(y), x >= 10 && x < 13, y >= 5 && y < 7, x < 8 && y < 4,
                        st && x == 0, st && x == 0 && y == 0, FC ? 16'(p / 120) : 16'd0};
                total++;
                if ({c_x, c_y, c_hs, c_vs, c_bl, c_ls, c_fs, c_fc} !== want) begin
                    bad++;
                    $display("FAIL sml_pixel p=%0d got=%h want=%h", p,
                             {c_x, c_y, c_hs, c_vs, c_bl, c_ls, c_fs, c_fc}, want);
                end
                p++;
            end
        end
        total++;
        if (fs1 != 363 || fs2 != 723) begin
            bad++;
            $display("FAIL frame_period fs at %0d,%0d want 363,723", fs1, fs2);
        end
    endtask

    task automatic test_reset_mid;
        repeat (3 * 51) @(negedge clk);
        total++;
        if ({c_x, c_y} !== {4'd6, 4'd3}) begin
            bad++;
            $display("FAIL mid_pos x/y got=%0d/%0d want=6/3", c_x, c_y);
        end
        @(posedge clk);
        #2 c_rst = 1'b0;
        #1;
        total++;
        if ({c_ce, c_x, c_y, c_ls, c_fs, c_hs, c_vs, c_bl, c_fc} !== 30'd0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", {c_ce, c_x, c_y, c_ls, c_fs, c_hs, c_vs, c_bl, c_fc});
        end
        @(negedge clk);
        c_rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (c_ce !== (i == 3)) begin
                bad++;
                $display("FAIL restart_ce edge=%0d got=%b want=%b", i, c_ce, (i == 3));
            end
        end
        total++;
        if ({c_x, c_y, c_fs, c_bl, c_fc} !== {4'd0, 4'd0, 1'b0, 1'b1, 16'd0}) begin
            bad++;
            $display("FAIL restart x/y/fs/bl/fc got=%0d/%0d/%b/%b/%0d want=0/0/0/1/0",
                     c_x, c_y, c_fs, c_bl, c_fc);
        end
    endtask

    initial begin
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_en  = 1'b1; b_en  = 1'b1; c_en  = 1'b1;
        test_reset;
        test_line;
        test_en;
        test_pipe_dly;
        test_frame;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
